// File: rtl/sdf_axi_lite_sequencer.sv
// sdf_axi_lite_sequencer
// AXI4-Lite master that drives an sdf_axi_wrapper through one transform:
// streams N coefficients in and writes them to addresses 0..N-1, issues the
// start / start-clear control pair, polls the status register for done, then
// reads the N results back and streams them out with out_last on the final beat.
// Optional build macro: SDF_SEQ_TIMEOUT_EN bounds the status polling to
// POLL_LIMIT reads; without it polling continues until done or reset.
module sdf_axi_lite_sequencer #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 5,
    parameter int N           = 16,
    parameter int CTRL_ADDR   = 16,
    parameter int STATUS_ADDR = 17,
    parameter int POLL_LIMIT  = 1024
) (
    input  logic                  s_axi_aclk,
    input  logic                  s_axi_aresetn,
    input  logic                  start,
    input  logic                  intt_mode,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy,
    output logic                  error,
    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [DATA_WIDTH-1:0] m_axi_wdata,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);

    localparam int IDX_W = $clog2(N);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_GET_IN   = 4'd1,
        S_WR       = 4'd2,
        S_WR_RESP  = 4'd3,
        S_CTRL_SET = 4'd4,
        S_CTRL_CLR = 4'd5,
        S_POLL_AR  = 4'd6,
        S_POLL_R   = 4'd7,
        S_POLL_GAP = 4'd8,
        S_RD_AR    = 4'd9,
        S_RD_R     = 4'd10,
        S_PUSH     = 4'd11,
        S_ERR      = 4'd12
    } state_t;

    // Which kind of write is in flight; decides where WR_RESP goes next.
    typedef enum logic [1:0] {
        PH_COEF = 2'd0,
        PH_SET  = 2'd1,
        PH_CLR  = 2'd2
    } phase_t;

    state_t               state_r;
    state_t               next_state_s;
    phase_t               phase_r;
    logic                 mode_r;
    logic [IDX_W-1:0]     idx_r;
    logic [IDX_W-1:0]     idx_nx_s;
    logic                 idx_last_s;
    logic                 start_fire_s;
    logic                 in_fire_s;
    logic                 b_ok_s;
    logic                 b_bad_s;
    logic                 r_ok_s;
    logic                 r_bad_s;
    logic                 r_done_s;
    logic                 push_fire_s;
    logic                 aw_clear_s;
    logic                 w_clear_s;
    logic                 poll_expired_s;
    logic                 in_ready_nx_s;
    logic                 awvalid_nx_s;
    logic                 wvalid_nx_s;
    logic                 bready_nx_s;
    logic                 arvalid_nx_s;
    logic                 rready_nx_s;
    logic                 out_valid_nx_s;
    logic                 out_last_nx_s;
    logic                 busy_nx_s;

    // Control word for the set (start) and clear halves of the control pair.
    function automatic logic [DATA_WIDTH-1:0] ctrl_word(input logic intt, input logic set_half);
        logic [DATA_WIDTH-1:0] word;
        case ({intt, set_half})
            2'b01:   word = DATA_WIDTH'(32'd5);
            2'b00:   word = DATA_WIDTH'(32'd4);
            2'b11:   word = DATA_WIDTH'(32'd3);
            2'b10:   word = DATA_WIDTH'(32'd2);
            default: word = DATA_WIDTH'(32'd0);
        endcase
        return word;
    endfunction

    assign idx_last_s   = (idx_r == IDX_W'(N - 1));
    assign start_fire_s = (state_r == S_IDLE) && start;
    assign in_fire_s    = in_valid && in_ready;
    assign b_ok_s       = m_axi_bvalid && (m_axi_bresp == 2'b00);
    assign b_bad_s      = m_axi_bvalid && (m_axi_bresp != 2'b00);
    assign r_ok_s       = m_axi_rvalid && (m_axi_rresp == 2'b00);
    assign r_bad_s      = m_axi_rvalid && (m_axi_rresp != 2'b00);
    assign r_done_s     = r_ok_s && m_axi_rdata[0];
    assign push_fire_s  = (state_r == S_PUSH) && out_ready;
    // A channel is clear once its valid is low or its handshake happens now.
    assign aw_clear_s   = !m_axi_awvalid || m_axi_awready;
    assign w_clear_s    = !m_axi_wvalid || m_axi_wready;

`ifdef SDF_SEQ_TIMEOUT_EN
    localparam int PC_W = $clog2(POLL_LIMIT + 1);
    logic [PC_W-1:0] poll_cnt_r;

    assign poll_expired_s = (poll_cnt_r == PC_W'(POLL_LIMIT - 1));

    // Count completed not-done status reads of the current transform.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            poll_cnt_r <= '0;
        end else if (state_r == S_CTRL_CLR) begin
            poll_cnt_r <= '0;
        end else if ((state_r == S_POLL_R) && r_ok_s && !m_axi_rdata[0]) begin
            poll_cnt_r <= poll_cnt_r + PC_W'(1'b1);
        end else begin
            poll_cnt_r <= poll_cnt_r;
        end
    end
`else
    // Polling only ends on done; the limit stays referenced so both builds share one parameter list.
    assign poll_expired_s = 1'b0 & (POLL_LIMIT > 0);
`endif

    // State register.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decision.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_IDLE:     if (start) next_state_s = S_GET_IN; else next_state_s = S_IDLE;
            S_GET_IN:   if (in_fire_s) next_state_s = S_WR; else next_state_s = S_GET_IN;
            S_WR:       if (aw_clear_s && w_clear_s) next_state_s = S_WR_RESP; else next_state_s = S_WR;
            S_WR_RESP: begin
                if (b_bad_s) begin
                    next_state_s = S_ERR;
                end else if (b_ok_s) begin
                    case (phase_r)
                        PH_COEF: next_state_s = idx_last_s ? S_CTRL_SET : S_GET_IN;
                        PH_SET:  next_state_s = S_CTRL_CLR;
                        PH_CLR:  next_state_s = S_POLL_AR;
                        default: next_state_s = S_ERR;
                    endcase
                end else begin
                    next_state_s = S_WR_RESP;
                end
            end
            S_CTRL_SET: next_state_s = S_WR;
            S_CTRL_CLR: next_state_s = S_WR;
            S_POLL_AR:  if (m_axi_arready) next_state_s = S_POLL_R; else next_state_s = S_POLL_AR;
            S_POLL_R: begin
                if (r_bad_s) begin
                    next_state_s = S_ERR;
                end else if (r_done_s) begin
                    next_state_s = S_RD_AR;
                end else if (r_ok_s) begin
                    next_state_s = poll_expired_s ? S_ERR : S_POLL_GAP;
                end else begin
                    next_state_s = S_POLL_R;
                end
            end
            S_POLL_GAP: next_state_s = S_POLL_AR;
            S_RD_AR:    if (m_axi_arready) next_state_s = S_RD_R; else next_state_s = S_RD_AR;
            S_RD_R: begin
                if (r_bad_s) begin
                    next_state_s = S_ERR;
                end else if (r_ok_s) begin
                    next_state_s = S_PUSH;
                end else begin
                    next_state_s = S_RD_R;
                end
            end
            S_PUSH: begin
                if (push_fire_s) begin
                    next_state_s = idx_last_s ? S_IDLE : S_RD_AR;
                end else begin
                    next_state_s = S_PUSH;
                end
            end
            S_ERR:      next_state_s = S_IDLE;
            default:    next_state_s = S_IDLE;
        endcase
    end

    // Next values of the handshake/status outputs, derived from the state being entered.
    always_comb begin
        in_ready_nx_s  = (next_state_s == S_GET_IN);
        bready_nx_s    = (next_state_s == S_WR_RESP);
        arvalid_nx_s   = (next_state_s == S_POLL_AR) || (next_state_s == S_RD_AR);
        rready_nx_s    = (next_state_s == S_POLL_R) || (next_state_s == S_RD_R);
        out_valid_nx_s = (next_state_s == S_PUSH);
        out_last_nx_s  = (next_state_s == S_PUSH) && idx_last_s;
        busy_nx_s      = (next_state_s != S_IDLE);
        // AW and W are raised together and each drops on its own handshake.
        if (next_state_s == S_WR) begin
            if (state_r == S_WR) begin
                awvalid_nx_s = m_axi_awvalid && !m_axi_awready;
                wvalid_nx_s  = m_axi_wvalid && !m_axi_wready;
            end else begin
                awvalid_nx_s = 1'b1;
                wvalid_nx_s  = 1'b1;
            end
        end else begin
            awvalid_nx_s = 1'b0;
            wvalid_nx_s  = 1'b0;
        end
    end

    // Registered handshake and status outputs.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            in_ready      <= 1'b0;
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
            out_valid     <= 1'b0;
            out_last      <= 1'b0;
            busy          <= 1'b0;
        end else begin
            in_ready      <= in_ready_nx_s;
            m_axi_awvalid <= awvalid_nx_s;
            m_axi_wvalid  <= wvalid_nx_s;
            m_axi_bready  <= bready_nx_s;
            m_axi_arvalid <= arvalid_nx_s;
            m_axi_rready  <= rready_nx_s;
            out_valid     <= out_valid_nx_s;
            out_last      <= out_last_nx_s;
            busy          <= busy_nx_s;
        end
    end

    // Coefficient index: advances after each good coefficient write and each pushed beat, wraps at N.
    always_comb begin
        idx_nx_s = idx_r;
        if (start_fire_s) begin
            idx_nx_s = {IDX_W{1'b0}};
        end else if ((state_r == S_WR_RESP) && b_ok_s && (phase_r == PH_COEF)) begin
            idx_nx_s = idx_last_s ? {IDX_W{1'b0}} : idx_r + IDX_W'(1'b1);
        end else if ((state_r == S_POLL_R) && r_done_s) begin
            idx_nx_s = {IDX_W{1'b0}};
        end else if (push_fire_s) begin
            idx_nx_s = idx_last_s ? {IDX_W{1'b0}} : idx_r + IDX_W'(1'b1);
        end else begin
            idx_nx_s = idx_r;
        end
    end

    // Index and transform-direction registers.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            idx_r  <= {IDX_W{1'b0}};
            mode_r <= 1'b0;
        end else if (start_fire_s) begin
            idx_r  <= idx_nx_s;
            mode_r <= intt_mode;
        end else begin
            idx_r  <= idx_nx_s;
            mode_r <= mode_r;
        end
    end

    // Sticky error: set on entering ERR, cleared only by an accepted start.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            error <= 1'b0;
        end else if (next_state_s == S_ERR) begin
            error <= 1'b1;
        end else if (start_fire_s) begin
            error <= 1'b0;
        end else begin
            error <= error;
        end
    end

    // Write address/data: the accepted coefficient, or the control word for the current half.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            m_axi_awaddr <= {ADDR_WIDTH{1'b0}};
            m_axi_wdata  <= {DATA_WIDTH{1'b0}};
            phase_r      <= PH_COEF;
        end else if ((state_r == S_GET_IN) && in_fire_s) begin
            m_axi_awaddr <= ADDR_WIDTH'(idx_r);
            m_axi_wdata  <= in_data;
            phase_r      <= PH_COEF;
        end else if (state_r == S_CTRL_SET) begin
            m_axi_awaddr <= ADDR_WIDTH'(CTRL_ADDR);
            m_axi_wdata  <= ctrl_word(mode_r, 1'b1);
            phase_r      <= PH_SET;
        end else if (state_r == S_CTRL_CLR) begin
            m_axi_awaddr <= ADDR_WIDTH'(CTRL_ADDR);
            m_axi_wdata  <= ctrl_word(mode_r, 1'b0);
            phase_r      <= PH_CLR;
        end else begin
            m_axi_awaddr <= m_axi_awaddr;
            m_axi_wdata  <= m_axi_wdata;
            phase_r      <= phase_r;
        end
    end

    // Read address loaded together with arvalid so it is valid on the first AR cycle.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            m_axi_araddr <= {ADDR_WIDTH{1'b0}};
        end else if ((next_state_s == S_POLL_AR) && (state_r != S_POLL_AR)) begin
            m_axi_araddr <= ADDR_WIDTH'(STATUS_ADDR);
        end else if ((next_state_s == S_RD_AR) && (state_r != S_RD_AR)) begin
            m_axi_araddr <= ADDR_WIDTH'(idx_nx_s);
        end else begin
            m_axi_araddr <= m_axi_araddr;
        end
    end

    // Result capture from a good read-data beat.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            out_data <= {DATA_WIDTH{1'b0}};
        end else if ((state_r == S_RD_R) && r_ok_s) begin
            out_data <= m_axi_rdata;
        end else begin
            out_data <= out_data;
        end
    end

endmodule

// File: tb/tb_sdf_axi_lite_sequencer.sv
// Bench for sdf_axi_lite_sequencer: a behavioural AXI-Lite slave standing in for
// the wrapper (memory, control register, status register, fake transform), a
// coefficient source, and a sink that checks every accepted output beat.
module tb_sdf_axi_lite_sequencer;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int N  = 16;
    localparam int CTRL = 16;
    localparam int PL = 1024;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0, intt_mode = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic in_valid = 1'b0, in_ready;
    logic [DW-1:0] out_data;
    logic out_valid, out_last, busy, error;
    logic out_ready = 1'b0;
    logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
    logic m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready;
    logic [DW-1:0] m_axi_wdata;
    logic m_axi_awready = 1'b0, m_axi_wready = 1'b0, m_axi_bvalid = 1'b0;
    logic m_axi_arready = 1'b0, m_axi_rvalid = 1'b0;
    logic [1:0] m_axi_bresp = 2'b00, m_axi_rresp = 2'b00;
    logic [DW-1:0] m_axi_rdata = '0;

    always #5 clk = ~clk;

    sdf_axi_lite_sequencer dut (
        .s_axi_aclk(clk), .s_axi_aresetn(rst_n), .start(start), .intt_mode(intt_mode),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .busy(busy), .error(error),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rready(m_axi_rready)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Stand-in for the wrapper's transform.
    function automatic logic [DW-1:0] xform(input logic [DW-1:0] x, input bit intt);
        if (intt) return x ^ 32'hA5A5_0F0F;
        return x * 32'd7 + 32'd1;
    endfunction

    // ---------------- slave model ----------------
    int aw_stall_left = 0;
    int err_wr_idx = -1;
    bit done_never = 1'b0;
    int polls_needed = 3;
    logic [DW-1:0] mem [0:N-1];
    logic [DW-1:0] res [0:N-1];
    bit got_aw = 0, got_w = 0, got_ar = 0, b_pend = 0, r_pend = 0, clr_seen = 0;
    logic [AW-1:0] aw_a, ar_a;
    logic [DW-1:0] w_d;
    int wr_count = 0, b_count = 0, status_reads = 0, aw_only = 0;
    logic [AW+DW-1:0] wlog [$];

    // Slave: responses and readies are updated at the falling edge, handshakes land on the next rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            got_aw = 0; got_w = 0; got_ar = 0; b_pend = 0; r_pend = 0;
            m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
            m_axi_bvalid = 0; m_axi_rvalid = 0; m_axi_bresp = 2'b00; m_axi_rresp = 2'b00;
        end else begin
            if (b_pend) begin m_axi_bvalid = 0; m_axi_bresp = 2'b00; b_pend = 0; end
            if (r_pend) begin m_axi_rvalid = 0; r_pend = 0; end
            if (got_aw && got_w && !m_axi_bvalid) begin
                wlog.push_back({aw_a, w_d});
                wr_count++;
                if (aw_a < AW'(N)) mem[aw_a[3:0]] = w_d;
                if (aw_a == AW'(CTRL) && (w_d == 32'd5 || w_d == 32'd3))
                    for (int i = 0; i < N; i++) res[i] = xform(mem[i], w_d == 32'd3);
                if (aw_a == AW'(CTRL) && (w_d == 32'd4 || w_d == 32'd2)) begin
                    clr_seen = 1; status_reads = 0;
                end
                m_axi_bvalid = 1;
                m_axi_bresp = (aw_a < AW'(N) && int'(aw_a) == err_wr_idx) ? 2'b10 : 2'b00;
                got_aw = 0; got_w = 0;
            end
            if (got_ar && !m_axi_rvalid) begin
                if (ar_a < AW'(N)) m_axi_rdata = res[ar_a[3:0]];
                else begin
                    m_axi_rdata = (clr_seen && !done_never && status_reads >= polls_needed) ? 32'h1 : 32'h2;
                    status_reads++;
                end
                m_axi_rresp = 2'b00; m_axi_rvalid = 1; got_ar = 0;
            end
            if (m_axi_awvalid && !m_axi_wvalid) aw_only++;
            if (m_axi_awvalid && aw_stall_left > 0) begin aw_stall_left--; m_axi_awready = 0; end
            else m_axi_awready = !got_aw;
            if (m_axi_awvalid && m_axi_awready) begin got_aw = 1; aw_a = m_axi_awaddr; end
            m_axi_wready = !got_w;
            if (m_axi_wvalid && m_axi_wready) begin got_w = 1; w_d = m_axi_wdata; end
            m_axi_arready = !got_ar && !m_axi_rvalid;
            if (m_axi_arvalid && m_axi_arready) begin got_ar = 1; ar_a = m_axi_araddr; end
            b_pend = m_axi_bvalid && m_axi_bready;
            if (b_pend) b_count++;
            r_pend = m_axi_rvalid && m_axi_rready;
        end
    end

    // ---------------- sink / compare ----------------
    bit toggle_ready = 0;
    logic [DW-1:0] exp_q [$];
    bit exp_last_q [$];
    logic [DW-1:0] obs [$];
    int beats = 0;

    // Sink: drive out_ready and check every beat accepted on the coming rising edge against the model.
    always @(negedge clk) begin
        if (toggle_ready) out_ready = ~out_ready;
        else out_ready = 1'b1;
        if (rst_n && out_valid && out_ready) begin
            beats++;
            obs.push_back(out_data);
            if (exp_q.size() == 0) begin
                chk("unexpected out beat", {63'd0, out_valid}, 64'd0);
            end else begin
                chk("out_data", out_data, exp_q.pop_front());
                chk("out_last", out_last, exp_last_q.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [DW-1:0] coef [0:N-1];

    task automatic do_start(input bit mode);
        @(negedge clk);
        start = 1; intt_mode = mode;
        @(negedge clk);
        start = 0; intt_mode = 0;
        chk("busy after start", busy, 1);
    endtask

    task automatic feed(input int count);
        int w;
        for (int k = 0; k < count; k++) begin
            in_valid = 1; in_data = coef[k];
            w = 0;
            while (!in_ready && w < 400) begin @(negedge clk); w++; end
            if (w >= 400) begin chk("feed in_ready", in_ready, 1); break; end
            @(negedge clk);
        end
        in_valid = 0;
    endtask

    task automatic wait_idle(input int limit);
        int w = 0;
        while (busy && w < limit) begin @(negedge clk); w++; end
        chk("return to idle", busy, 0);
    endtask

    task automatic clear_logs();
        wlog.delete(); exp_q.delete(); exp_last_q.delete(); obs.delete();
        beats = 0; wr_count = 0; b_count = 0; aw_only = 0; clr_seen = 0; status_reads = 0;
    endtask

    task automatic run_flow(input bit mode, input logic [DW-1:0] base, input logic [DW-1:0] step);
        logic [AW+DW-1:0] e;
        clear_logs();
        for (int i = 0; i < N; i++) begin
            coef[i] = base + DW'(i) * step;
            exp_q.push_back(xform(coef[i], mode));
            exp_last_q.push_back(i == N - 1);
        end
        do_start(mode);
        feed(N);
        wait_idle(5000);
        chk("beat count", beats, N);
        chk("error after flow", error, 0);
        chk("write count", wlog.size(), N + 2);
        chk("b count", b_count, N + 2);
        for (int i = 0; i < N + 2 && i < wlog.size(); i++) begin
            if (i < N) e = {AW'(i), coef[i]};
            else if (i == N) e = {AW'(CTRL), mode ? 32'd3 : 32'd5};
            else e = {AW'(CTRL), mode ? 32'd2 : 32'd4};
            chk($sformatf("write %0d", i), wlog[i], e);
        end
    endtask

    initial begin
        int w;
        int ctrl_writes;
        repeat (3) @(negedge clk);
        chk("reset valids", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}, 64'd0);
        chk("reset stream", {in_ready, out_valid, out_last, busy, error}, 64'd0);
        chk("reset addr/data", {m_axi_awaddr, m_axi_araddr, m_axi_wdata, out_data}, 64'd0);
        rst_n = 1;

        // in_valid in IDLE is not accepted
        in_valid = 1; in_data = 32'h1234;
        repeat (3) @(negedge clk);
        chk("idle in_ready", in_ready, 0);
        chk("idle busy", busy, 0);
        in_valid = 0;

        // NTT, slave always ready
        run_flow(0, 32'h10, 32'h101);
        chk("ntt beat0 literal", obs.size() > 0 ? obs[0] : 32'hX, 32'h71);
        chk("ntt beat15 literal", obs.size() > 15 ? obs[15] : 32'hX, 32'h69DA);

        // INTT with AW stalled on the first write and out_ready toggling
        aw_stall_left = 4; toggle_ready = 1;
        run_flow(1, 32'hDEAD_0000, 32'h1);
        chk("intt beat0 literal", obs.size() > 0 ? obs[0] : 32'hX, 32'h7B08_0F0F);
        chk("aw held after W", aw_only, 4);
        toggle_ready = 0;

        // Error response on third coefficient write
        clear_logs(); err_wr_idx = 2;
        for (int i = 0; i < N; i++) coef[i] = 32'h100 + DW'(i);
        do_start(0);
        feed(3);
        w = 0;
        while (!error && w < 200) begin @(negedge clk); w++; end
        chk("bresp error", error, 1);
        @(negedge clk);
        chk("busy after error", busy, 0);
        repeat (5) @(negedge clk);
        ctrl_writes = 0;
        foreach (wlog[i]) if (wlog[i][AW+DW-1:DW] == AW'(CTRL)) ctrl_writes++;
        chk("no control write", ctrl_writes, 0);
        chk("writes before error", wlog.size(), 3);
        chk("no beats after error", beats, 0);
        chk("error sticky", error, 1);
        err_wr_idx = -1;

        // Next start clears error and completes normally
        run_flow(0, 32'hABCD_0000, 32'h11);

        // Reset held two cycles in the middle of a write
        clear_logs(); aw_stall_left = 100;
        do_start(0);
        coef[0] = 32'h55;
        feed(1);
        w = 0;
        while (!m_axi_awvalid && w < 50) begin @(negedge clk); w++; end
        chk("awvalid before reset", m_axi_awvalid, 1);
        #2 rst_n = 0;
        #1;
        chk("reset drops valids", {m_axi_awvalid, m_axi_wvalid}, 64'd0);
        chk("reset drops busy", busy, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1; aw_stall_left = 0;
        repeat (2) @(negedge clk);
        chk("idle after reset", {busy, in_ready, m_axi_awvalid, error}, 64'd0);

        // Recovery after reset
        run_flow(1, 32'h0F0F_0001, 32'h303);

`ifdef SDF_SEQ_TIMEOUT_EN
        // Done never set: error after exactly PL status reads
        clear_logs(); done_never = 1;
        for (int i = 0; i < N; i++) coef[i] = DW'(i);
        do_start(0);
        feed(N);
        w = 0;
        while (!error && w < 20000) begin @(negedge clk); w++; end
        chk("timeout error", error, 1);
        chk("status reads at timeout", status_reads, PL);
        repeat (3) @(negedge clk);
        chk("busy after timeout", busy, 0);
        chk("no beats on timeout", beats, 0);
        done_never = 0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
